c_onehot_split32: RTL
=====================

Name: c_onehot_split32

Overview:
- Clocked 32-way one-hot splitter: the dispatch side of the 32-to-1 mutex-merge control path.
- Accepts one token, with a 32-bit one-hot channel select in the same format the merge emits on o_data.
- Drives the selected downstream channel, waits for that channel's free, then returns a single free upstream.
- Sits between the merged request stream and the 32 per-way consumers of the cache replacement controller.

Parameters:
- N_CH, 32, number of output channels; i_sel is one-hot over N_CH.
- TIMEOUT, 255, max WAIT cycles before forced release; 0 disables the timeout.
- IDX_W, 5, width of o_chan; must be at least clog2(N_CH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_drive  input  1  upstream token; sampled only in IDLE.
- i_sel  input  N_CH  one-hot target channel; sampled with i_drive.
- o_free  output  1  one-cycle pulse: token consumed, upstream may send the next one.
- o_drive  output  N_CH  one-cycle one-hot pulse to the selected channel.
- i_freeNext  input  N_CH  per-channel completion from downstream.
- o_chan  output  IDX_W  binary index of the latched channel; held until the next accept.
- o_busy  output  1  high in every state except IDLE.
- o_err  output  2  sticky flags. Bit0: bad select (zero or multi-hot). Bit1: timeout. Cleared only by rst.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately when asserted):
  - State goes to IDLE. o_drive, o_free, o_chan, o_err and the wait counter all go to 0.
  - Any outstanding token is dropped and no o_free is issued for it.
- All outputs are registered; there are no combinational input-to-output paths.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - i_drive=1 with one-hot i_sel: latch sel_q=i_sel and o_chan=encode(i_sel), then go to ISSUE.
  - i_drive=1 with zero or multi-hot i_sel: set o_err[0], drive no channel, go straight to ACK. o_chan is unchanged.
  - i_drive=0: stay in IDLE.
- ISSUE:
  - o_drive=sel_q for exactly this cycle.
  - If i_freeNext & sel_q is nonzero this cycle, go to ACK; otherwise go to WAIT with the counter cleared.
- WAIT:
  - o_drive=0.
  - If i_freeNext & sel_q is nonzero, go to ACK.
  - Otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1, set o_err[1] and go to ACK.
  - Otherwise increment the counter; it saturates and never wraps.
- ACK:
  - o_free=1 for exactly this cycle, then go to IDLE.
  - Next acceptance is possible in the cycle after ACK.
- Latency with immediate free:
  - Edge n samples i_drive. o_drive is high in cycle n+1.
  - i_freeNext[k] high in cycle n+1 gives o_free high in cycle n+2.
  - Minimum token period is 3 cycles.
- Latency with free in WAIT: o_free is high in the cycle after the edge that samples i_freeNext[k].
- Protocol violations:
  - i_drive asserted while not IDLE is ignored; no error flag is set.
  - i_freeNext on a non-selected channel is ignored in every state.
  - i_freeNext seen in IDLE or ACK is ignored and is not remembered.
- A late i_freeNext arriving after a timeout is ignored. It does not affect the next token unless that token targets the same channel and the free is still high in its ISSUE cycle.
- Simultaneous free and timeout in the same WAIT cycle: free wins and o_err[1] is not set.
- Encoder: o_chan is the index of the single set bit; it is only updated on a valid one-hot accept.

Test Plan:
- Reset behaviour: assert rst mid-WAIT with i_sel=32'h0000_0100 in flight -> o_busy, o_drive, o_free and o_err all 0 immediately; no o_free pulse after rst deasserts.
- Nominal dispatch: i_drive with i_sel=32'h0000_0004, i_freeNext[2] raised 3 cycles after o_drive -> o_drive=32'h4 for one cycle, o_chan=2, o_free pulses one cycle after the free is sampled, o_err=0.
- Back-to-back tokens: i_sel=32'h8000_0000 then 32'h0000_0001, each with free in the ISSUE cycle -> o_chan goes 31 then 0, o_free pulses 3 cycles apart, o_drive never multi-hot.
- Bad select: i_drive with i_sel=32'h0000_0000, then 32'h0000_0003 -> no o_drive, o_free 1 cycle after each accept, o_err[0]=1 and sticky.
- Timeout (TIMEOUT=4): i_sel=32'h0001_0000 and i_freeNext[16] held 0 -> o_free 4 WAIT cycles after ISSUE, o_err=2'b10; a later i_freeNext[16] pulse in IDLE has no effect.
- Free race: i_freeNext[5] and i_freeNext[6] asserted while sel=bit5, on the exact timeout cycle -> ACK via free, o_err[1]=0; channel 6's free is ignored.

Source files
------------

// File: rtl/c_onehot_split32.sv
// One-hot dispatch splitter: accepts a token with a one-hot channel select, pulses the
// chosen downstream channel, waits for its free (or a timeout), then returns one free upstream.
module c_onehot_split32 #(
    parameter int N_CH    = 32,
    parameter int TIMEOUT = 255,
    parameter int IDX_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_drive,
    input  logic [N_CH-1:0]   i_sel,
    output logic              o_free,
    output logic [N_CH-1:0]   o_drive,
    input  logic [N_CH-1:0]   i_freeNext,
    output logic [IDX_W-1:0]  o_chan,
    output logic              o_busy,
    output logic [1:0]        o_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [N_CH-1:0]  SEL_ONE  = N_CH'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t            state;
    state_t            state_nx;
    logic [N_CH-1:0]   sel_q;
    logic              sel_ld;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [IDX_W-1:0]  chan_nx;
    logic [1:0]        err_nx;
    logic              hit;

    function automatic logic is_onehot(input logic [N_CH-1:0] v);
        return (v != '0) && ((v & (v - SEL_ONE)) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] encode(input logic [N_CH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (v[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    // Only the latched channel's free counts; others are ignored in every state.
    assign hit = |(i_freeNext & sel_q);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        chan_nx  = o_chan;
        err_nx   = o_err;
        sel_ld   = 1'b0;
        case (state)
            IDLE: begin
                if (i_drive) begin
                    if (is_onehot(i_sel)) begin
                        sel_ld   = 1'b1;
                        chan_nx  = encode(i_sel);
                        state_nx = ISSUE;
                    end else begin
                        err_nx[0] = 1'b1;
                        state_nx  = ACK;
                    end
                end
            end
            ISSUE: begin
                cnt_nx   = '0;
                state_nx = hit ? ACK : WAIT;
            end
            WAIT: begin
                // Free has priority over a timeout landing in the same cycle.
                if (hit) begin
                    state_nx = ACK;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    err_nx[1] = 1'b1;
                    state_nx  = ACK;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            o_chan <= '0;
            o_err  <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            o_chan <= chan_nx;
            o_err  <= err_nx;
        end
    end

    // Select register carries data only; it is read solely in ISSUE/WAIT after a load.
    always_ff @(posedge clk) begin
        if (sel_ld) sel_q <= i_sel;
    end

    assign o_drive = (state == ISSUE) ? sel_q : '0;
    assign o_free  = (state == ACK);
    assign o_busy  = (state != IDLE);

endmodule
